// File: rtl/ram_responder_if.sv
// CPU RAM port and loader byte stream bundled for ram_responder.
// master = CPU/loader side, slave = memory responder.
interface ram_responder_if;
  logic        ram_read;
  logic        ram_write;
  logic [23:0] ram_address;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic        ld_valid;
  logic [7:0]  ld_byte;
  logic        ld_ready;

  modport master (
    output ram_read, ram_write, ram_address, ram_wdata,
    output ld_valid, ld_byte,
    input  ram_rdata, ld_ready
  );

  modport slave (
    input  ram_read, ram_write, ram_address, ram_wdata,
    input  ld_valid, ld_byte,
    output ram_rdata, ld_ready
  );
endinterface

// File: rtl/ram_responder.sv
// Word-addressed RAM + output register serving the CPU RAM port,
// with a byte-stream boot loader that holds the CPU in reset.
module ram_responder #(
  parameter int          DEPTH_LOG2 = 10,
  parameter logic [23:0] IO_ADDR    = 24'hFFFFFF,
  parameter bit          LOADER_EN  = 1'b1
) (
  input  logic                  clk,
  input  logic                  nreset,
  ram_responder_if.slave        bus,
  output logic                  cpu_nreset,
  output logic [31:0]           io_out,
  output logic                  bad_access
);
  localparam int DEPTH = 2 ** DEPTH_LOG2;

  typedef enum logic [1:0] {
    HDR0,
    HDR1,
    DATA,
    RUN
  } state_t;

  localparam state_t RST_STATE =
    LOADER_EN ? HDR0 : RUN;

  state_t      state;
  state_t      state_nxt;
  logic [15:0] count;
  logic [15:0] idx;
  logic [1:0]  lane;
  logic [23:0] asm_q;

  logic xfer;
  logic run;
  logic last_byte;
  logic in_ram;
  logic is_io;
  logic cpu_rd;
  logic cpu_wr;

  logic [31:0]           mem [DEPTH];
  logic                  mem_we;
  logic [DEPTH_LOG2-1:0] mem_waddr;
  logic [31:0]           mem_wdata;

  assign bus.ld_ready = nreset && (state != RUN);
  assign xfer      = bus.ld_valid && bus.ld_ready;
  assign run       = nreset && (state == RUN);
  assign last_byte = (state == DATA) && xfer
                  && (lane == 2'd3);
  assign in_ram = 32'(bus.ram_address) < 32'(DEPTH);
  assign is_io  = bus.ram_address == IO_ADDR;
  assign cpu_rd = run && bus.ram_read;
  assign cpu_wr = run && bus.ram_write;

  always_comb begin
    state_nxt = state;
    unique case (state)
      HDR0: if (xfer) state_nxt = HDR1;
      HDR1: begin
        if (xfer)
          state_nxt = ({bus.ld_byte, count[7:0]} == 16'd0)
                    ? RUN : DATA;
      end
      DATA: begin
        if (last_byte && (idx + 16'd1 == count))
          state_nxt = RUN;
      end
      RUN:  state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state      <= RST_STATE;
      cpu_nreset <= 1'b0;
      count      <= '0;
      idx        <= '0;
      lane       <= '0;
      asm_q      <= '0;
      io_out     <= '0;
      bad_access <= 1'b0;
    end else begin
      state      <= state_nxt;
      cpu_nreset <= (state_nxt == RUN);
      if (xfer) begin
        unique case (state)
          HDR0: count[7:0] <= bus.ld_byte;
          HDR1: begin
            count[15:8] <= bus.ld_byte;
            idx         <= '0;
            lane        <= '0;
          end
          DATA: begin
            // lanes 0..2 shift in; lane 3 completes the word
            asm_q <= {bus.ld_byte, asm_q[23:8]};
            lane  <= lane + 2'd1;
            if (lane == 2'd3) idx <= idx + 16'd1;
          end
          default: ;
        endcase
      end
      if (cpu_wr && !in_ram && is_io)
        io_out <= bus.ram_wdata;
      if ((cpu_rd || cpu_wr) && !in_ram && !is_io)
        bad_access <= 1'b1;
      if (cpu_rd && cpu_wr)
        bad_access <= 1'b1;
    end
  end

  // loader and CPU writes never coincide: loader only outside RUN
  assign mem_we = last_byte
                ? (32'(idx) < 32'(DEPTH))
                : (cpu_wr && in_ram);
  assign mem_waddr = last_byte
                   ? idx[DEPTH_LOG2-1:0]
                   : bus.ram_address[DEPTH_LOG2-1:0];
  assign mem_wdata = last_byte
                   ? {bus.ld_byte, asm_q}
                   : bus.ram_wdata;

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  always_comb begin
    bus.ram_rdata = '0;
    if (cpu_rd) begin
      if (in_ram)
        bus.ram_rdata =
          mem[bus.ram_address[DEPTH_LOG2-1:0]];
      else if (is_io)
        bus.ram_rdata = io_out;
    end
  end
endmodule

// File: tb/tb_ram_responder.sv
// Randomized scoreboard bench for ram_responder: stimulus
// queues expectations, a negedge monitor compares them.
module tb_ram_responder;
  localparam int          DEPTH = 1024;
  localparam logic [23:0] IO    = 24'hFFFFFF;

  logic clk = 1'b0;
  logic nreset = 1'b0;
  always #5 clk = ~clk;

  ram_responder_if bus ();
  ram_responder_if bus2 ();

  logic        cpu_nreset, cpu_nreset2;
  logic        bad, bad2;
  logic [31:0] io_out, io_out2;

  ram_responder #(
    .DEPTH_LOG2(10), .IO_ADDR(IO), .LOADER_EN(1'b1)
  ) dut (
    .clk(clk), .nreset(nreset), .bus(bus.slave),
    .cpu_nreset(cpu_nreset), .io_out(io_out),
    .bad_access(bad)
  );

  ram_responder #(
    .DEPTH_LOG2(10), .IO_ADDR(IO), .LOADER_EN(1'b0)
  ) dut2 (
    .clk(clk), .nreset(nreset), .bus(bus2.slave),
    .cpu_nreset(cpu_nreset2), .io_out(io_out2),
    .bad_access(bad2)
  );

  typedef struct {
    string       name;
    int          kind;
    logic [31:0] exp;
  } chk_t;

  chk_t sb[$];
  int   checks = 0;
  int   failures = 0;
  bit   done = 1'b0;

  logic [31:0] m_mem [DEPTH];
  bit          m_known [DEPTH];
  logic [31:0] m_io;
  bit          m_bad;
  bit          m_run;
  bit          m_cpu2;

  function automatic logic [31:0] sample(int k);
    case (k)
      0: return bus.ram_rdata;
      1: return {31'b0, cpu_nreset};
      2: return {31'b0, bus.ld_ready};
      3: return io_out;
      4: return {31'b0, bad};
      5: return {31'b0, cpu_nreset2};
      6: return {31'b0, bus2.ld_ready};
      7: return bus2.ram_rdata;
      8: return {31'b0, bad2};
      default: return 32'hx;
    endcase
  endfunction

  always @(negedge clk) begin : monitor
    chk_t        c;
    logic [31:0] act;
    while (sb.size() > 0) begin
      c = sb.pop_front();
      act = sample(c.kind);
      checks++;
      if (act !== c.exp) begin
        failures++;
        $display("FAIL %s: got %h want %h @%0t",
                 c.name, act, c.exp, $time);
      end
    end
  end

  task automatic check_now(string n,
                           logic [31:0] act,
                           logic [31:0] e);
    checks++;
    if (act !== e) begin
      failures++;
      $display("FAIL %s: got %h want %h @%0t",
               n, act, e, $time);
    end
  endtask

  initial begin : watchdog
    #2ms;
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL timeout: bench did not finish @%0t",
               $time);
      $display("TB_RESULT checks=%0d failures=%0d",
               checks, failures);
      $finish;
    end
  end

  task automatic want(string n, int k,
                      logic [31:0] e);
    chk_t c;
    c.name = n;
    c.kind = k;
    c.exp  = e;
    sb.push_back(c);
  endtask

  task automatic status();
    want("cpu_nreset", 1, {31'b0, m_run});
    want("ld_ready", 2, {31'b0, !m_run});
    want("io_out", 3, m_io);
    want("bad_access", 4, {31'b0, m_bad});
    want("cpu_nreset_noload", 5, {31'b0, m_cpu2});
    want("ld_ready_noload", 6, 32'd0);
    want("rdata_noload", 7, 32'd0);
    want("bad_noload", 8, 32'd0);
    m_cpu2 = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    bus2.ld_byte = 8'($urandom);
  endtask

  function automatic logic [23:0] rand_addr(bit bad_ok);
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return IO;
    if (r == 1 && bad_ok)
      return 24'(DEPTH + $urandom_range(0, 1000));
    if (r == 2 && bad_ok) return 24'hFFFFFE;
    return 24'($urandom_range(0, DEPTH - 1));
  endfunction

  task automatic cpu(bit rd, bit wr,
                     logic [23:0] a, logic [31:0] d);
    bit inr, iio;
    tick();
    bus.ram_read    = rd;
    bus.ram_write   = wr;
    bus.ram_address = a;
    bus.ram_wdata   = d;
    bus.ld_valid    = 1'($urandom);
    bus.ld_byte     = 8'($urandom);
    status();
    inr = (a < DEPTH);
    iio = (a == IO);
    if (!rd)
      want("rdata_idle", 0, 32'd0);
    else if (inr) begin
      if (m_known[a[9:0]])
        want("rdata_mem", 0, m_mem[a[9:0]]);
    end else if (iio)
      want("rdata_io", 0, m_io);
    else
      want("rdata_bad", 0, 32'd0);
    if (wr) begin
      if (inr) begin
        m_mem[a[9:0]]   = d;
        m_known[a[9:0]] = 1'b1;
      end else if (iio)
        m_io = d;
    end
    if (((rd || wr) && !inr && !iio) || (rd && wr))
      m_bad = 1'b1;
  endtask

  task automatic load(input logic [7:0] b[$],
                      input bit complete,
                      input bit gaps);
    int          i;
    int          n;
    bit          v;
    logic [31:0] w;
    i = 0;
    while (i < b.size()) begin
      tick();
      v = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      bus.ld_valid    = v;
      bus.ld_byte     = v ? b[i] : 8'($urandom);
      bus.ram_read    = 1'($urandom);
      bus.ram_write   = 1'($urandom);
      bus.ram_address = rand_addr(1'b1);
      bus.ram_wdata   = $urandom;
      status();
      want("rdata_loading", 0, 32'd0);
      if (v) i++;
    end
    if (complete) begin
      n = {b[1], b[0]};
      for (int k = 0; k < n && k < DEPTH; k++) begin
        w = {b[2+4*k+3], b[2+4*k+2],
             b[2+4*k+1], b[2+4*k]};
        m_mem[k]   = w;
        m_known[k] = 1'b1;
      end
      m_run = 1'b1;
    end
  endtask

  task automatic do_reset();
    tick();
    nreset          = 1'b0;
    bus.ld_valid    = 1'b1;
    bus.ram_read    = 1'b1;
    bus.ram_write   = 1'b1;
    bus.ram_address = 24'd0;
    bus.ram_wdata   = $urandom;
    m_run = 1'b0;
    m_io  = '0;
    m_bad = 1'b0;
    #1;
    check_now("now_cpu_nreset", {31'b0, cpu_nreset}, 32'd0);
    check_now("now_ld_ready", {31'b0, bus.ld_ready}, 32'd0);
    check_now("now_io_out", io_out, 32'd0);
    check_now("now_bad", {31'b0, bad}, 32'd0);
    check_now("now_cpu_nreset_noload",
              {31'b0, cpu_nreset2}, 32'd0);
    check_now("now_ld_ready_noload",
              {31'b0, bus2.ld_ready}, 32'd0);
    check_now("now_io_out_noload", io_out2, 32'd0);
    check_now("now_bad_noload", {31'b0, bad2}, 32'd0);
    check_now("now_rdata_noload", bus2.ram_rdata, 32'd0);
    want("rst_cpu_nreset", 1, 32'd0);
    want("rst_ld_ready", 2, 32'd0);
    want("rst_io_out", 3, 32'd0);
    want("rst_bad", 4, 32'd0);
    want("rst_cpu_nreset_noload", 5, 32'd0);
    want("rst_ld_ready_noload", 6, 32'd0);
    want("rst_rdata", 0, 32'd0);
    tick();
    nreset        = 1'b1;
    bus.ld_valid  = 1'b0;
    bus.ram_read  = 1'b0;
    bus.ram_write = 1'b0;
    m_cpu2 = 1'b0;
    status();
    want("rel_rdata", 0, 32'd0);
  endtask

  initial begin
    logic [7:0] q[$];
    int         r;

    bus.ram_read     = 1'b0;
    bus.ram_write    = 1'b0;
    bus.ram_address  = '0;
    bus.ram_wdata    = '0;
    bus.ld_valid     = 1'b0;
    bus.ld_byte      = '0;
    bus2.ram_read    = 1'b0;
    bus2.ram_write   = 1'b0;
    bus2.ram_address = '0;
    bus2.ram_wdata   = '0;
    bus2.ld_valid    = 1'b1;
    bus2.ld_byte     = '0;
    for (int k = 0; k < DEPTH; k++) m_known[k] = 1'b0;
    m_io = '0;
    m_bad = 1'b0;
    m_run = 1'b0;
    m_cpu2 = 1'b0;
    repeat (2) @(posedge clk);

    do_reset();
    q = {8'h00, 8'h00};
    load(q, 1'b1, 1'b0);
    repeat (3) cpu(1'b0, 1'b0, 24'd0, 32'd0);

    do_reset();
    q = {8'h01, 8'h00, 8'h5A, 8'h6B};
    load(q, 1'b0, 1'b1);
    do_reset();

    q = {8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
         8'hAA, 8'hBB, 8'hCC, 8'hDD};
    load(q, 1'b1, 1'b1);
    cpu(1'b1, 1'b0, 24'd0, 32'd0);
    want("spec_word0", 0, 32'h44332211);
    cpu(1'b1, 1'b0, 24'd1, 32'd0);
    want("spec_word1", 0, 32'hDDCCBBAA);
    cpu(1'b0, 1'b1, 24'd5, 32'hCAFEF00D);
    cpu(1'b1, 1'b0, 24'd5, 32'd0);
    want("spec_cafe", 0, 32'hCAFEF00D);
    cpu(1'b0, 1'b1, IO, 32'h0000_00A5);
    cpu(1'b1, 1'b0, IO, 32'd0);
    want("spec_io", 3, 32'hA5);
    cpu(1'b0, 1'b0, 24'd0, 32'd0);
    cpu(1'b1, 1'b0, 24'd1024, 32'd0);
    cpu(1'b1, 1'b0, 24'd0, 32'd0);
    want("spec_bad_set", 4, 32'd1);
    cpu(1'b0, 1'b1, 24'd3, 32'h1234);
    cpu(1'b0, 1'b0, 24'd0, 32'd0);

    do_reset();
    q = {8'h02, 8'h04};
    for (int k = 0; k < 4 * (DEPTH + 2); k++)
      q.push_back(8'($urandom));
    load(q, 1'b1, 1'b1);
    cpu(1'b1, 1'b0, 24'd0, 32'd0);
    cpu(1'b1, 1'b0, 24'd1023, 32'd0);
    repeat (400) begin
      r = $urandom_range(0, 2);
      cpu(r == 0, r == 1, rand_addr(1'b0), $urandom);
    end
    cpu(1'b0, 1'b1, 24'd5, 32'hCAFEF00D);
    cpu(1'b1, 1'b1, 24'd5, 32'h12345678);
    want("rw_old", 0, 32'hCAFEF00D);
    cpu(1'b1, 1'b0, 24'd5, 32'd0);
    want("rw_new", 0, 32'h12345678);
    want("rw_bad", 4, 32'd1);
    repeat (300) begin
      cpu(1'($urandom), 1'($urandom),
          rand_addr(1'b1), $urandom);
    end
    cpu(1'b0, 1'b0, 24'd0, 32'd0);
    @(negedge clk);
    #1;
    done = 1'b1;
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end
endmodule
